// File: rtl/prog_loader_pkg.sv
// ============================================================================
// prog_loader_pkg : command bytes, FSM states and target select for prog_loader
// Revision: 1.0
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  localparam logic [7:0] CMD_LOAD_IMEM = 8'hA5;
  localparam logic [7:0] CMD_LOAD_DMEM = 8'h5A;
  localparam logic [7:0] CMD_RUN       = 8'h0F;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    WRITE,
    RUN
  } loader_state_t;

  typedef enum logic {
    SEL_IMEM,
    SEL_DMEM
  } mem_sel_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader_word_assembler.sv
// ============================================================================
// prog_loader_word_assembler : packs four bytes, LSB first, into a 32-bit word
// Revision: 1.0
// ============================================================================
`default_nettype none

module prog_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_done
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_valid) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_byte;
      r_idx                        <= r_idx + 2'd1;
    end
  end

  // Done is flagged with the 4th byte so the FSM can move to WRITE on that edge.
  assign o_done = i_valid && (r_idx == 2'd3);
  assign o_word = r_word;

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : host byte stream to IMEM/DMEM word writes, CPU reset control
// Revision: 1.0
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_rst_no,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [16:0] c_imem_depth = 17'(IMEM_WORDS);
  localparam logic [16:0] c_dmem_depth = 17'(DMEM_WORDS);

  loader_state_t r_state;
  mem_sel_t      r_sel;
  logic [15:0]   r_cnt;
  logic [15:0]   r_word_idx;

  logic          w_accept;
  logic          w_asm_valid;
  logic [31:0]   w_word;
  logic          w_word_done;
  logic [16:0]   w_depth;
  logic [15:0]   w_cnt_new;
  logic          w_in_range;

  assign w_accept    = rx_valid_i && rx_ready_o;
  assign w_asm_valid = w_accept && (r_state == DATA);
  assign w_depth     = (r_sel == SEL_IMEM) ? c_imem_depth : c_dmem_depth;
  assign w_cnt_new   = {rx_data_i, r_cnt[7:0]};
  assign w_in_range  = {1'b0, r_word_idx} < w_depth;

  prog_loader_word_assembler u_asm (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_valid (w_asm_valid),
    .i_byte  (rx_data_i),
    .o_word  (w_word),
    .o_done  (w_word_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_sel       <= SEL_IMEM;
      r_cnt       <= 16'd0;
      r_word_idx  <= 16'd0;
      rx_ready_o  <= 1'b1;
      imem_we_o   <= 1'b0;
      dmem_we_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'd0;
      cpu_rst_no  <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      imem_we_o <= 1'b0;
      dmem_we_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (rx_data_i)
              CMD_LOAD_IMEM: begin
                r_sel      <= SEL_IMEM;
                r_word_idx <= 16'd0;
                r_state    <= CNT_LO;
              end
              CMD_LOAD_DMEM: begin
                r_sel      <= SEL_DMEM;
                r_word_idx <= 16'd0;
                r_state    <= CNT_LO;
              end
              CMD_RUN: begin
                r_state    <= RUN;
                rx_ready_o <= 1'b0;
                cpu_rst_no <= 1'b1;
              end
              default: err_o <= 1'b1;
            endcase
          end
        end
        CNT_LO: begin
          if (w_accept) begin
            r_cnt[7:0] <= rx_data_i;
            r_state    <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (w_accept) begin
            r_cnt <= w_cnt_new;
            if (w_cnt_new == 16'd0) begin
              r_state <= IDLE;
            end else begin
              r_state <= DATA;
              busy_o  <= 1'b1;
            end
            if ({1'b0, w_cnt_new} > w_depth) err_o <= 1'b1;
          end
        end
        DATA: begin
          if (w_word_done) begin
            r_state    <= WRITE;
            rx_ready_o <= 1'b0;
          end
        end
        WRITE: begin
          // Out-of-range words are consumed silently; the bus keeps its last values.
          if (w_in_range) begin
            imem_we_o   <= (r_sel == SEL_IMEM);
            dmem_we_o   <= (r_sel == SEL_DMEM);
            mem_addr_o  <= r_word_idx[ADDR_W-1:0];
            mem_wdata_o <= w_word;
          end
          r_word_idx <= r_word_idx + 16'd1;
          r_cnt      <= r_cnt - 16'd1;
          rx_ready_o <= 1'b1;
          if (r_cnt == 16'd1) begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
          end else begin
            r_state <= DATA;
          end
        end
        RUN: begin
          rx_ready_o <= 1'b0;
          cpu_rst_no <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader : directed and randomized frames against a write-list model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;

  localparam int c_imem = 4;
  localparam int c_dmem = 8;

  logic        clk;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        imem_we_o;
  logic        dmem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        cpu_rst_no;
  logic        busy_o;
  logic        err_o;

  prog_loader #(
    .ADDR_W     (10),
    .IMEM_WORDS (c_imem),
    .DMEM_WORDS (c_dmem)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .imem_we_o   (imem_we_o),
    .dmem_we_o   (dmem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .cpu_rst_no  (cpu_rst_no),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Write records are {target(1=DMEM), addr[9:0], data[31:0]}.
  logic [42:0] obs_q[$];
  logic [42:0] exp_q[$];
  logic [31:0] words[$];
  int          both_hi, ready_low;
  bit          busy_seen;
  bit          exp_err;
  logic [9:0]  exp_addr;
  logic [31:0] exp_data;
  logic [7:0]  bad;
  bit          sel;
  int          n, stall;

  always @(negedge clk) begin
    if (imem_we_o) obs_q.push_back({1'b0, mem_addr_o, mem_wdata_o});
    if (dmem_we_o) obs_q.push_back({1'b1, mem_addr_o, mem_wdata_o});
    if (imem_we_o && dmem_we_o) both_hi++;
    if (busy_o) busy_seen = 1'b1;
    if (!rx_ready_o && !rst_i) ready_low++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall_cycles);
    int bound;
    repeat (stall_cycles) @(negedge clk);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    bound = 0;
    while (!rx_ready_o && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 100) chk("rx_ready_timeout", 64'(rx_ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic clear_mon();
    @(negedge clk);
    #1;
    obs_q.delete();
    both_hi   = 0;
    ready_low = 0;
    busy_seen = 1'b0;
    @(negedge clk);
  endtask

  // Reference: word i of a frame lands at address i only if i < depth; overlong frames flag error.
  task automatic model_load(input bit dmem, input int cnt);
    int depth;
    depth = dmem ? c_dmem : c_imem;
    for (int i = 0; i < cnt; i++) begin
      if (i < depth) begin
        exp_q.push_back({dmem, 10'(i), words[i]});
        exp_addr = 10'(i);
        exp_data = words[i];
      end
    end
    if (cnt > depth) exp_err = 1'b1;
  endtask

  task automatic send_frame(input bit dmem, input int cnt, input int stall_cycles);
    send_byte(dmem ? 8'h5A : 8'hA5, stall_cycles);
    send_byte(cnt[7:0], stall_cycles);
    send_byte(cnt[15:8], stall_cycles);
    for (int i = 0; i < cnt; i++)
      for (int k = 0; k < 4; k++)
        send_byte(words[i][8*k +: 8], stall_cycles);
  endtask

  task automatic check_frame(input string tag, input int cnt);
    repeat (4) @(negedge clk);
    #1;
    chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
    chk({tag, "_both_strobes"}, 64'(both_hi), 64'd0);
    chk({tag, "_ready_low_cycles"}, 64'(ready_low), 64'(cnt));
    chk({tag, "_busy_seen"}, 64'(busy_seen), 64'(cnt > 0));
    chk({tag, "_busy_end"}, 64'(busy_o), 64'd0);
    chk({tag, "_ready_end"}, 64'(rx_ready_o), 64'd1);
    chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
    chk({tag, "_addr_hold"}, 64'(mem_addr_o), 64'(exp_addr));
    chk({tag, "_wdata_hold"}, 64'(mem_wdata_o), 64'(exp_data));
    chk({tag, "_cpu_rst"}, 64'(cpu_rst_no), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 64'(rx_ready_o), 64'd1);
    chk({tag, "_imem_we"}, 64'(imem_we_o), 64'd0);
    chk({tag, "_dmem_we"}, 64'(dmem_we_o), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata_o), 64'd0);
    chk({tag, "_cpu_rst"}, 64'(cpu_rst_no), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
  endtask

  initial begin
    rst_i      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    exp_err    = 1'b0;
    exp_addr   = 10'd0;
    exp_data   = 32'd0;
    #2;
    check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    // IMEM load of two instructions at full rate
    clear_mon();
    words = '{32'h00A00513, 32'h00B00593};
    model_load(1'b0, 2);
    send_frame(1'b0, 2, 0);
    check_frame("imem2", 2);

    // Same words to DMEM with three idle cycles before every byte
    clear_mon();
    model_load(1'b1, 2);
    send_frame(1'b1, 2, 3);
    check_frame("dmem_stall", 2);

    // Bad command is flagged, next load still works
    clear_mon();
    send_byte(8'h33, 0);
    @(negedge clk);
    chk("badcmd_err", 64'(err_o), 64'd1);
    exp_err = 1'b1;
    words = '{32'hDEADBEEF};
    model_load(1'b0, 1);
    send_frame(1'b0, 1, 0);
    check_frame("after_bad", 1);

    // Overflow: five words into a four-word IMEM
    clear_mon();
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    model_load(1'b0, 5);
    send_frame(1'b0, 5, 0);
    check_frame("overflow", 5);

    // Randomized frames, including overlong ones and junk command bytes
    for (int f = 0; f < 8; f++) begin
      clear_mon();
      if ($urandom_range(0, 3) == 0) begin
        do bad = 8'($urandom); while (bad == 8'hA5 || bad == 8'h5A || bad == 8'h0F);
        send_byte(bad, 0);
        exp_err = 1'b1;
      end
      sel   = 1'($urandom_range(0, 1));
      n     = $urandom_range(0, 10);
      stall = $urandom_range(0, 2);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      model_load(sel, n);
      send_frame(sel, n, stall);
      check_frame("random", n);
    end

    // Asynchronous reset after two data bytes of a one-word load
    clear_mon();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst_i = 1'b1;
    #1;
    check_reset_values("midword_rst");
    @(negedge clk);
    rst_i    = 1'b0;
    exp_err  = 1'b0;
    exp_addr = 10'd0;
    exp_data = 32'd0;
    clear_mon();
    words = '{32'h12345678};
    model_load(1'b0, 1);
    send_frame(1'b0, 1, 0);
    check_frame("after_rst", 1);

    // Zero-count frame, then RUN
    clear_mon();
    words.delete();
    model_load(1'b1, 0);
    send_frame(1'b1, 0, 0);
    check_frame("zero_cnt", 0);
    send_byte(8'h0F, 0);
    repeat (10) @(negedge clk);
    chk("run_cpu_rst", 64'(cpu_rst_no), 64'd1);
    chk("run_ready", 64'(rx_ready_o), 64'd0);
    chk("run_busy_seen", 64'(busy_seen), 64'd0);
    chk("run_nwrites", 64'(obs_q.size()), 64'd0);
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hA5;
    repeat (5) @(negedge clk);
    rx_valid_i = 1'b0;
    chk("run_stays", 64'(cpu_rst_no), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    check_reset_values("run_rst");
    @(negedge clk);
    rst_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
